// File: rtl/canny_pkg.sv
// Shared constants, pixel type and window indexing for the Canny pipeline stages.
package canny_pkg;

    localparam int KSIZE     = 5;
    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 514;
    localparam int IMG_H_DEF = 514;

    typedef logic [PIX_W-1:0] pixel_t;

    // Row-major flat index of window element (r,c); r=0 is the top row, c=0 the oldest column.
    function automatic int win_idx(input int r, input int c);
        return r * KSIZE + c;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position tracker with line/frame wrap and start-of-frame resync.
module raster_counter #(
    parameter int W_MAX = 514,
    parameter int H_MAX = 514
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_adv,
    input  logic                       i_sof,
    output logic [$clog2(W_MAX)-1:0]   o_px,
    output logic [$clog2(H_MAX)-1:0]   o_py,
    output logic                       o_last
);

    localparam int XW = $clog2(W_MAX);
    localparam int YW = $clog2(H_MAX);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_px;
    logic [YW-1:0] w_py;
    logic          w_x_wrap;
    logic          w_y_wrap;

    // sof overrides the running counters so the current column is (0,0).
    always_comb begin
        w_px     = i_sof ? '0 : r_x;
        w_py     = i_sof ? '0 : r_y;
        w_x_wrap = (w_px == XW'(W_MAX - 1));
        w_y_wrap = (w_py == YW'(H_MAX - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_x_wrap) begin
                r_x <= '0;
                r_y <= w_y_wrap ? '0 : w_py + YW'(1);
            end else begin
                r_x <= w_px + XW'(1);
                r_y <= w_py;
            end
        end
    end

    assign o_px   = w_px;
    assign o_py   = w_py;
    assign o_last = w_x_wrap && w_y_wrap;

endmodule

// File: rtl/win5x5_assembler.sv
// Assembles line-buffer column taps into a sliding 5x5 window with in-image validity,
// centre coordinates and an end-of-frame pulse.
module win5x5_assembler
    import canny_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = canny_pkg::PIX_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_col_valid,
    input  logic                             i_sof,
    input  logic [KSIZE*PIX_W-1:0]           i_col_data,
    output logic [KSIZE*KSIZE*PIX_W-1:0]     o_win_data,
    output logic                             o_win_valid,
    output logic [$clog2(IMG_W)-1:0]         o_ctr_x,
    output logic [$clog2(IMG_H)-1:0]         o_ctr_y,
    output logic                             o_frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [PIX_W-1:0] r_win [KSIZE*KSIZE];
    logic             r_win_valid;
    logic [XW-1:0]    r_ctr_x;
    logic [YW-1:0]    r_ctr_y;
    logic             r_frame_done;

    logic [XW-1:0]    w_px;
    logic [YW-1:0]    w_py;
    logic             w_last;
    logic             w_in_img;

    raster_counter #(
        .W_MAX (IMG_W),
        .H_MAX (IMG_H)
    ) u_raster_counter (
        .clk    (clk),
        .rst    (rst),
        .i_adv  (i_col_valid),
        .i_sof  (i_sof),
        .o_px   (w_px),
        .o_py   (w_py),
        .o_last (w_last)
    );

    // A window is whole once KSIZE columns of the current line have arrived, below KSIZE-1 lines.
    assign w_in_img = (w_px >= XW'(KSIZE - 1)) && (w_py >= YW'(KSIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KSIZE * KSIZE; i++) begin
                r_win[i] <= '0;
            end
        end else if (i_col_valid) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    r_win[win_idx(r, c)] <= r_win[win_idx(r, c + 1)];
                end
                r_win[win_idx(r, KSIZE - 1)] <= i_col_data[r*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_ctr_x      <= '0;
            r_ctr_y      <= '0;
        end else begin
            r_win_valid  <= i_col_valid && w_in_img;
            r_frame_done <= i_col_valid && w_last;
            if (i_col_valid && w_in_img) begin
                r_ctr_x <= w_px - XW'(KSIZE / 2);
                r_ctr_y <= w_py - YW'(KSIZE / 2);
            end
        end
    end

    for (genvar i = 0; i < KSIZE * KSIZE; i++) begin : g_flat
        assign o_win_data[i*PIX_W +: PIX_W] = r_win[i];
    end

    assign o_win_valid  = r_win_valid;
    assign o_ctr_x      = r_ctr_x;
    assign o_ctr_y      = r_ctr_y;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_win5x5_assembler.sv
// Scoreboard bench for win5x5_assembler on an 8x6 image with column-position-coded pixels.
module tb_win5x5_assembler;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;

    logic           clk;
    logic           rst;
    logic           i_col_valid;
    logic           i_sof;
    logic [5*PW-1:0]  i_col_data;
    logic [25*PW-1:0] o_win_data;
    logic           o_win_valid;
    logic [2:0]     o_ctr_x;
    logic [2:0]     o_ctr_y;
    logic           o_frame_done;

    win5x5_assembler #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_col_valid  (i_col_valid),
        .i_sof        (i_sof),
        .i_col_data   (i_col_data),
        .o_win_data   (o_win_data),
        .o_win_valid  (o_win_valid),
        .o_ctr_x      (o_ctr_x),
        .o_ctr_y      (o_ctr_y),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25*PW-1:0] win;
        logic [2:0]       cx;
        logic [2:0]       cy;
        logic             done;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_valid = 0;
    int   n_done  = 0;
    int   m_x = 0;
    int   m_y = 0;
    logic prev_cv = 1'b0;

    // Column c of a window accepted at px holds the pixels of column px-4+c.
    function automatic logic [25*PW-1:0] exp_win(input int px);
        logic [25*PW-1:0] v;
        v = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                v[(r*5+c)*PW +: PW] = {4'(r), 4'(px - 4 + c)};
            end
        end
        return v;
    endfunction

    task automatic send(input logic s);
        int px;
        int py;
        exp_t e;
        @(posedge clk);
        #1;
        px = s ? 0 : m_x;
        py = s ? 0 : m_y;
        i_col_valid = 1'b1;
        i_sof       = s;
        for (int r = 0; r < 5; r++) begin
            i_col_data[r*PW +: PW] = {4'(r), 4'(px)};
        end
        if (px >= 4 && py >= 4) begin
            e.win  = exp_win(px);
            e.cx   = 3'(px - 2);
            e.cy   = 3'(py - 2);
            e.done = (px == W - 1) && (py == H - 1);
            q.push_back(e);
        end
        m_x = (px == W - 1) ? 0 : px + 1;
        m_y = (px == W - 1) ? ((py == H - 1) ? 0 : py + 1) : py;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            i_col_valid = 1'b0;
            i_sof       = 1'b0;
        end
    endtask

    task automatic run_cols(input int n, input logic first_sof, input int gap);
        for (int i = 0; i < n; i++) begin
            send(first_sof && (i == 0));
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        n_cmp++;
        if (o_win_data !== '0 || o_win_valid !== 1'b0 || o_ctr_x !== 3'd0 ||
            o_ctr_y !== 3'd0 || o_frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got valid=%b done=%b ctr=(%0d,%0d) win=%h, expected all zero",
                     name, o_win_valid, o_frame_done, o_ctr_x, o_ctr_y, o_win_data);
        end
    endtask

    // Monitor: pops an expectation for every presented window.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (!prev_cv) begin
                n_cmp++;
                if (o_win_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL valid_after_gap: got win_valid=%b, expected 0", o_win_valid);
                end
            end
            if (o_frame_done === 1'b1) n_done++;
            if (o_win_valid === 1'b1) begin
                n_valid++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_window: got ctr=(%0d,%0d), expected no window",
                             o_ctr_x, o_ctr_y);
                end else begin
                    e = q.pop_front();
                    if (o_win_data !== e.win || o_ctr_x !== e.cx || o_ctr_y !== e.cy ||
                        o_frame_done !== e.done) begin
                        n_err++;
                        $display("FAIL window: got ctr=(%0d,%0d) done=%b win=%h, expected ctr=(%0d,%0d) done=%b win=%h",
                                 o_ctr_x, o_ctr_y, o_frame_done, o_win_data,
                                 e.cx, e.cy, e.done, e.win);
                    end
                end
            end else if (o_frame_done === 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_without_valid: got frame_done=1, expected 0");
            end
        end
        prev_cv = i_col_valid;
    end

    initial begin
        int v0;
        int d0;
        rst         = 1'b1;
        i_col_valid = 1'b0;
        i_sof       = 1'b0;
        i_col_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        rst = 1'b0;

        // Full frame, continuous.
        v0 = n_valid; d0 = n_done;
        run_cols(W * H, 1'b1, 0);
        idle(3);
        check_int("frame1_valid_count", n_valid - v0, 8);
        check_int("frame1_done_count", n_done - d0, 1);

        // Same frame with two idle cycles between columns.
        v0 = n_valid; d0 = n_done;
        run_cols(W * H, 1'b1, 2);
        idle(3);
        check_int("gap_valid_count", n_valid - v0, 8);
        check_int("gap_done_count", n_done - d0, 1);

        // sof at (5,2): 2 full lines plus 5 columns, then a fresh frame.
        v0 = n_valid; d0 = n_done;
        run_cols(2 * W + 5, 1'b1, 0);
        idle(2);
        check_int("pre_resync_valid", n_valid - v0, 0);
        check_int("resync_pos_x", m_x, 5);
        run_cols(W * 5, 1'b1, 0);
        idle(2);
        check_int("resync_no_early_done", n_done - d0, 0);
        run_cols(W, 1'b0, 0);
        idle(3);
        check_int("resync_valid_count", n_valid - v0, 8);
        check_int("resync_done_count", n_done - d0, 1);

        // Reset mid-row, then a frame without sof.
        run_cols(W + 3, 1'b1, 0);
        @(posedge clk);
        #1;
        i_col_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_x = 0;
        m_y = 0;
        check_zero_outputs("mid_reset_outputs");
        v0 = n_valid; d0 = n_done;
        run_cols(W * H, 1'b0, 0);
        idle(3);
        check_int("post_reset_valid_count", n_valid - v0, 8);
        check_int("post_reset_done_count", n_done - d0, 1);

        check_int("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/win5x5_assembler.md
Name: win5x5_assembler

Overview:
- Consumer end of the 5-tap line buffer. It takes the 5 vertically aligned pixels the buffer produces per accepted pixel and assembles them into a sliding 5x5 neighbourhood window for the Gaussian and Sobel stages of the Canny pipeline.
- It tracks raster position and flags which windows are fully inside the image. It also reports the centre-pixel coordinates and signals end of frame.

Parameters:
- IMG_W, 514, pixels per line; must match the line-buffer length.
- IMG_H, 514, lines per frame.
- PIX_W, 8, bits per pixel.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- col_valid  in  1  col_data is a new column; advance window and counters
- sof  in  1  start of frame; qualified by col_valid; the current column is pixel (0,0)
- col_data  in  5*PIX_W  vertical taps; slice r = col_data[r*PIX_W +: PIX_W]; r=0 oldest line (top), r=4 current line
- win_data  out  25*PIX_W  window; element (r,c) = win_data[(r*5+c)*PIX_W +: PIX_W]; r=0 top, c=0 oldest (leftmost) column
- win_valid  out  1  win_data is a complete in-image 5x5 window
- ctr_x  out  clog2(IMG_W)  x of window centre, valid with win_valid
- ctr_y  out  clog2(IMG_H)  y of window centre, valid with win_valid
- frame_done  out  1  one-cycle pulse after the last pixel of the frame

Behaviour:
- Reset: win_data=0, win_valid=0, ctr_x=0, ctr_y=0, frame_done=0, internal x=0, y=0, all window registers=0. Reset in mid-frame discards the partial window and counters; the next accepted column is treated as (0,0).
- Window shift on each clk with col_valid=1:
  - column c <= column c+1 for c=0..3;
  - column 4 <= col_data.
- col_valid=0: window, counters and ctr_* hold; win_valid=0; frame_done=0. Gaps of any length are legal.
- Position counters:
  - Position of the accepted column is (px,py) = sof ? (0,0) : (x,y).
  - Afterwards x <= px+1, or 0 when px=IMG_W-1.
  - y increments when px wraps. It wraps to 0 after IMG_H-1.
- sof with col_valid=1 at a non-zero position resyncs the counters to (0,0). Window contents are not cleared; they are masked by the validity rule.
- Validity and latency:
  - win_valid is registered and asserts the cycle after accepting a column with px>=4 and py>=4.
  - In that cycle ctr_x=px-2 and ctr_y=py-2, and win_data includes the accepted column. Latency is 1 clk.
  - Columns with px<4 on any line hold stale pixels from the previous line; win_valid=0 for them.
  - Border pixels (x<2, x>IMG_W-3, y<2, y>IMG_H-3) never get a valid window. Downstream stages zero-fill these.
- frame_done: registered, asserts the cycle after accepting px=IMG_W-1, py=IMG_H-1, coincident with the final win_valid.
- Arithmetic: counters are unsigned, width clog2 of their limit. No data arithmetic is performed.

Decomposition:
- Shared package canny_pkg:
  - KSIZE=5
  - PIX_W=8
  - default IMG_W/IMG_H
  - pixel typedef
  - window-index helper function (r*KSIZE+c).
- Sub-module raster_counter (x/y counters with wrap, sof resync, last-pixel flag). It is reused by later pipeline stages.
- Window register file and output registers stay inline.

Test Plan:
- Bench uses IMG_W=8, IMG_H=6. Stimulus per column: slice r = {r[3:0], px[3:0]}.
- Full frame, col_valid held 1, sof on first column:
  - win_valid high exactly 8 cycles (px 4..7 on py 4..5);
  - first assertion has ctr=(2,2) and element (r,c)={r, c};
  - frame_done pulses once, with the final win_valid, ctr=(5,3).
- Same frame with col_valid toggling 1,0,0,1:
  - identical sequence of win_data/ctr values;
  - win_valid never asserts in a cycle following col_valid=0.
- Line wrap: on py=5, px=0..3 accepted -> win_valid=0; px=4 -> win_valid=1, ctr=(2,3), column 0 = {r,4'h0}.
- sof at (5,2) mid-frame -> counters restart; no win_valid until new (4,4); frame_done only after the new frame's last pixel.
- rst asserted mid-row for one cycle -> all outputs 0 next cycle; the following frame without sof still produces the first valid window at ctr=(2,2).
